// File: rtl/mem_burst_master_if.sv
// rtl/mem_burst_master_if.sv - host command/data streams and memory bus bundle for mem_burst_master
//
// Groups every handshake and memory-side signal of the burst master.
//   master modport : the burst master's view (drives cmd_ready, wdata_ready,
//                    rdata*, done, mem_we/mem_addr/mem_wdata)
//   slave modport  : the host plus memory view (drives commands, write beats,
//                    rdata_ready, mem_rdata)
interface mem_burst_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;

    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] wdata;

    logic              rdata_valid;
    logic              rdata_ready;
    logic [DATA_W-1:0] rdata;
    logic              rdata_last;

    logic              done;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        output cmd_ready,
        input  wdata_valid, wdata,
        output wdata_ready,
        output rdata_valid, rdata, rdata_last,
        input  rdata_ready,
        output done,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  cmd_ready,
        output wdata_valid, wdata,
        input  wdata_ready,
        input  rdata_valid, rdata, rdata_last,
        output rdata_ready,
        input  done,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_burst_master.sv
// rtl/mem_burst_master.sv - burst initiator for an 8-bit synchronous single-port memory
//
// Turns host burst commands into per-beat memory cycles and returns read data
// over a valid/ready stream.
//   clk    : single rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : mem_burst_master_if.master
//            cmd_*   burst command (write flag, start address, beats-1)
//            wdata_* write beat stream into the memory
//            rdata_* read beat stream back to the host, rdata_last on final beat
//            done    one-cycle pulse when a burst has fully completed
//            mem_*   memory port; mem_rdata is valid the cycle after a read address
module mem_burst_master #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_burst_master_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DONE
    } state_t;

    localparam logic [LEN_W:0]  BEAT_ONE = (LEN_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [1:0]      CNT_ONE  = 2'd1;
    localparam logic [1:0]      CNT_FULL = 2'd2;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_q;       // address of the next beat to write/issue
    logic [ADDR_W-1:0] mem_addr_q;   // last driven mem_addr, so the bus holds when idle
    logic [LEN_W:0]    rem_cnt;      // beats still to be accepted (write) or delivered (read)
    logic [LEN_W:0]    iss_cnt;      // read beats still to be issued to the memory
    logic              pending;      // a read was issued last cycle; mem_rdata is valid now

    logic [DATA_W-1:0] fifo_q [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        fifo_cnt, fifo_cnt_nx;

    logic              cmd_acc, wr_acc, pop, issue;
    logic [LEN_W:0]    cmd_beats;

    assign cmd_beats       = {1'b0, bus.cmd_len} + BEAT_ONE;
    assign pop             = (fifo_cnt != 2'd0) && bus.rdata_ready;
    assign bus.rdata_valid = (fifo_cnt != 2'd0);
    assign bus.rdata       = fifo_q[rd_ptr];
    assign bus.rdata_last  = (fifo_cnt != 2'd0) && (rem_cnt == BEAT_ONE);

    // Buffer occupancy after this cycle's capture and pop; equals the
    // count-plus-in-flight figure the issue decision has to respect.
    always_comb begin
        fifo_cnt_nx = fifo_cnt;
        case ({pending, pop})
            2'b10:   fifo_cnt_nx = fifo_cnt + CNT_ONE;
            2'b01:   fifo_cnt_nx = fifo_cnt - CNT_ONE;
            default: fifo_cnt_nx = fifo_cnt;
        endcase
    end

    always_comb begin
        state_nx        = state;
        bus.cmd_ready   = 1'b0;
        bus.wdata_ready = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_wdata   = '0;
        bus.mem_addr    = mem_addr_q;
        bus.done        = 1'b0;
        cmd_acc         = 1'b0;
        wr_acc          = 1'b0;
        issue           = 1'b0;

        case (state)
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
                cmd_acc       = bus.cmd_valid;
                if (bus.cmd_valid) begin
                    state_nx = bus.cmd_write ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                bus.wdata_ready = 1'b1;
                bus.mem_addr    = addr_q;
                bus.mem_wdata   = bus.wdata;
                bus.mem_we      = bus.wdata_valid;
                wr_acc          = bus.wdata_valid;
                if (bus.wdata_valid && (rem_cnt == BEAT_ONE)) begin
                    state_nx = S_DONE;
                end
            end
            S_READ: begin
                // Issue only if the new beat still fits once everything in
                // flight has landed in the two-entry buffer.
                if ((iss_cnt != '0) && (fifo_cnt_nx != CNT_FULL)) begin
                    issue        = 1'b1;
                    bus.mem_addr = addr_q;
                end
                if (pop && (rem_cnt == BEAT_ONE)) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            mem_addr_q <= '0;
            rem_cnt    <= '0;
            iss_cnt    <= '0;
            pending    <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_cnt   <= 2'd0;
        end else begin
            state      <= state_nx;
            mem_addr_q <= bus.mem_addr;
            pending    <= issue;
            fifo_cnt   <= fifo_cnt_nx;

            if (cmd_acc) begin
                addr_q  <= bus.cmd_addr;
                rem_cnt <= cmd_beats;
                iss_cnt <= bus.cmd_write ? '0 : cmd_beats;
            end else begin
                if (wr_acc || issue) begin
                    addr_q <= addr_q + ADDR_ONE;
                end
                if (wr_acc || pop) begin
                    rem_cnt <= rem_cnt - BEAT_ONE;
                end
                if (issue) begin
                    iss_cnt <= iss_cnt - BEAT_ONE;
                end
            end

            if (pending) begin
                fifo_q[wr_ptr] <= bus.mem_rdata;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end
endmodule
